// File: rtl/ha_array_pkg.sv
// ha_array_pkg: shared widths, FSM state and row-pair type for the ha_array accumulator.
package ha_array_pkg;
  localparam int NUM_GROUPS = 4;
  localparam int B_W = 7;
  localparam int T_W = 9;
  localparam int OUT_W = 16;
  localparam int ACC_W = 18;
  localparam int GRP_W = $clog2(NUM_GROUPS);
  localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'((1 << OUT_W) - 1);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  typedef struct packed {
    logic [B_W-1:0] b;
    logic [T_W-1:0] t;
  } row_t;
  function automatic logic [OUT_W-1:0] saturate(input logic [ACC_W-1:0] a);
    return (a > OUT_MAX) ? '1 : a[OUT_W-1:0];
  endfunction
endpackage

// File: rtl/ha_array_accumulator_if.sv
// ha_array_accumulator_if: row-set input and product output handshakes of the ha_array accumulator.
interface ha_array_accumulator_if import ha_array_pkg::*; ();
  logic in_valid;
  logic in_ready;
  logic [NUM_GROUPS-1:0][B_W-1:0] ha_array_g_b;
  logic [NUM_GROUPS-1:0][T_W-1:0] ha_array_g_t;
  logic out_valid;
  logic out_ready;
  logic [OUT_W-1:0] product;
  logic overflow;
  modport master (output in_valid, ha_array_g_b, ha_array_g_t, out_ready,
                  input in_ready, out_valid, product, overflow);
  modport slave (input in_valid, ha_array_g_b, ha_array_g_t, out_ready,
                 output in_ready, out_valid, product, overflow);
endinterface

// File: rtl/ha_group_weight.sv
// ha_group_weight: weighted term (t + (b << 2)) << 2g of one row-pair group at accumulator width.
module ha_group_weight import ha_array_pkg::*; (
  input  row_t             row,
  input  logic [GRP_W-1:0] grp,
  output logic [ACC_W-1:0] term
);
  assign term = (ACC_W'(row.t) + (ACC_W'(row.b) << 2)) << {grp, 1'b0};
endmodule

// File: rtl/ha_array_accumulator.sv
// ha_array_accumulator: iterative reducer of the four ha_array row pairs into a saturated 16-bit product.
// HA_ARRAY_ACC_DUAL_EN adds two groups per accumulate cycle instead of one.
module ha_array_accumulator import ha_array_pkg::*; (
  input logic clk,
  input logic rst,
  ha_array_accumulator_if.slave io
);
  state_t state;
  row_t rows [NUM_GROUPS];
  logic [GRP_W-1:0] grp;
  logic [ACC_W-1:0] acc, acc_nxt, term_a;
  logic last;
  ha_group_weight u_weight_a (.row(rows[grp]), .grp(grp), .term(term_a));
`ifdef HA_ARRAY_ACC_DUAL_EN
  localparam logic [GRP_W-1:0] STEP = GRP_W'(2);
  logic [ACC_W-1:0] term_b;
  ha_group_weight u_weight_b (.row(rows[grp + GRP_W'(1)]), .grp(grp + GRP_W'(1)), .term(term_b));
  assign acc_nxt = acc + term_a + term_b;
  assign last = grp == GRP_W'(NUM_GROUPS - 2);
`else
  localparam logic [GRP_W-1:0] STEP = GRP_W'(1);
  assign acc_nxt = acc + term_a;
  assign last = grp == GRP_W'(NUM_GROUPS - 1);
`endif
  assign io.in_ready = state == IDLE;
  always_ff @(posedge clk)
    if (state == IDLE && io.in_valid)
      for (int g = 0; g < NUM_GROUPS; g++) rows[g] <= '{b: io.ha_array_g_b[g], t: io.ha_array_g_t[g]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      grp <= '0;
      io.out_valid <= 1'b0;
      io.product <= '0;
      io.overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.in_valid) begin
          acc <= '0;
          grp <= '0;
          state <= ACCUM;
        end
        ACCUM: begin
          acc <= acc_nxt;
          grp <= grp + STEP;
          if (last) begin
            state <= DONE;
            io.out_valid <= 1'b1;
            io.product <= saturate(acc_nxt);
            io.overflow <= acc_nxt > OUT_MAX;
          end
        end
        DONE: if (io.out_ready) begin
          state <= IDLE;
          io.out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ha_array_accumulator.sv
// tb_ha_array_accumulator: directed checks of product, saturation, latency, backpressure and reset.
module tb_ha_array_accumulator;
  import ha_array_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
`ifdef HA_ARRAY_ACC_DUAL_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 4;
`endif
  ha_array_accumulator_if io();
  ha_array_accumulator dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic accept(input string tag, input logic [3:0][6:0] b, input logic [3:0][8:0] t);
    io.ha_array_g_b = b;
    io.ha_array_g_t = t;
    io.in_valid = 1'b1;
    chk({tag, "_in_ready_pre"}, 32'(io.in_ready), 1);
    step();
    io.in_valid = 1'b0;
    io.ha_array_g_b = ~b;
    io.ha_array_g_t = ~t;
    chk({tag, "_in_ready_busy"}, 32'(io.in_ready), 0);
  endtask
  task automatic wait_out(input string tag);
    int lat = 0;
    while (!io.out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(LAT));
  endtask
  task automatic run(input string tag, input logic [3:0][6:0] b, input logic [3:0][8:0] t,
                     input logic [15:0] want_p, input logic want_o);
    accept(tag, b, t);
    wait_out(tag);
    chk({tag, "_product"}, 32'(io.product), 32'(want_p));
    chk({tag, "_overflow"}, 32'(io.overflow), 32'(want_o));
    io.out_ready = 1'b1;
    step();
    io.out_ready = 1'b0;
    chk({tag, "_out_valid_clr"}, 32'(io.out_valid), 0);
    chk({tag, "_in_ready_back"}, 32'(io.in_ready), 1);
  endtask
  initial begin
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    io.ha_array_g_b = '0;
    io.ha_array_g_t = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(io.in_ready), 1);
    chk("rst_out_valid", 32'(io.out_valid), 0);
    chk("rst_product", 32'(io.product), 0);
    chk("rst_overflow", 32'(io.overflow), 0);
    run("zeros", '0, '0, 16'h0000, 1'b0);
    run("g0_t1", '0, {9'h000, 9'h000, 9'h000, 9'h001}, 16'h0001, 1'b0);
    run("g1_b1", {7'h00, 7'h00, 7'h01, 7'h00}, '0, 16'h0010, 1'b0);
    run("g3_max", {7'h7F, 7'h00, 7'h00, 7'h00}, {9'h1FF, 9'h000, 9'h000, 9'h000}, 16'hFEC0, 1'b0);
    run("all_max", {7'h7F, 7'h7F, 7'h7F, 7'h7F}, {9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF}, 16'hFFFF, 1'b1);
    run("mix", {7'h00, 7'h00, 7'h00, 7'h02}, {9'h000, 9'h003, 9'h000, 9'h000}, 16'h0038, 1'b0);
    accept("hold", {7'h00, 7'h00, 7'h01, 7'h00}, '0);
    wait_out("hold");
    io.in_valid = 1'b1;
    io.ha_array_g_b = '1;
    io.ha_array_g_t = '1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_product", 32'(io.product), 32'h0010);
      chk("hold_out_valid", 32'(io.out_valid), 1);
      chk("hold_in_ready", 32'(io.in_ready), 0);
    end
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    step();
    io.out_ready = 1'b0;
    chk("hold_release_in_ready", 32'(io.in_ready), 1);
    chk("hold_release_out_valid", 32'(io.out_valid), 0);
    step();
    chk("hold_nothing_captured", 32'(io.in_ready), 1);
    accept("mid_rst", {7'h7F, 7'h7F, 7'h7F, 7'h7F}, {9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF});
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_out_valid", 32'(io.out_valid), 0);
    chk("mid_rst_in_ready", 32'(io.in_ready), 1);
    chk("mid_rst_product", 32'(io.product), 0);
    chk("mid_rst_overflow", 32'(io.overflow), 0);
    chk("mid_rst_acc", 32'(dut.acc), 0);
    run("after_rst", {7'h00, 7'h00, 7'h00, 7'h02}, {9'h000, 9'h003, 9'h000, 9'h000}, 16'h0038, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
